xpb_lut_ram: RTL and testbench

- Runtime-loadable, multi-channel successor to the hard-coded xpb constant tables used in the modular-square reduction path.
- Holds NUM_TABLES tables of 2^SEL_BITS precomputed reduction words each. A new modulus is installed by loading words instead of re-synthesising.
- Serves one lookup per table per cycle through a fixed 2-cycle pipeline.
- Tracks which entries are loaded; reports per-table "armed" status and per-lane misses.

---
 rtl/xpb_lut_ram.sv | 170 +++++++++++++++++
 tb/tb_xpb_lut_ram.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xpb_lut_ram.sv
// Runtime-loadable reduction-word tables for the modular-square path.
// NUM_TABLES independent tables of 2^SEL_BITS words, one lookup per table per
// cycle with a fixed two-cycle latency. Entry 0 of every table is a hardwired
// zero. A written bitmap tracks loaded entries, drives per-lane miss flags and
// marks a table "armed" once entries 1..2^SEL_BITS-1 are all loaded.
module xpb_lut_ram #(
    parameter  int SEL_BITS   = 5,
    parameter  int DATA_W     = 1024,
    parameter  int NUM_TABLES = 4,
    localparam int TBL_W      = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         ld_valid,
    input  logic [TBL_W-1:0]             ld_table,
    input  logic [SEL_BITS-1:0]          ld_index,
    input  logic [DATA_W-1:0]            ld_data,
    input  logic                         lk_valid,
    input  logic [NUM_TABLES*SEL_BITS-1:0] lk_sel,
    output logic                         out_valid,
    output logic [NUM_TABLES*DATA_W-1:0] out_data,
    output logic [NUM_TABLES-1:0]        out_miss,
    output logic [NUM_TABLES-1:0]        tbl_armed
);

    localparam int DEPTH = 1 << SEL_BITS;

    // Written bitmap and armed flags
    logic [DEPTH-1:0]      written_q [NUM_TABLES];
    logic [DEPTH-1:0]      written_d [NUM_TABLES];
    logic [NUM_TABLES-1:0] armed_q;
    logic [NUM_TABLES-1:0] armed_d;
    logic [NUM_TABLES-1:0] wr_en;

    // Stage 1 of the lookup pipeline
    logic                         s1_valid_q;
    logic [NUM_TABLES*SEL_BITS-1:0] s1_sel_q;
    logic [NUM_TABLES-1:0]        s1_hit_q;
    logic [NUM_TABLES-1:0]        s1_hit_d;
    logic [NUM_TABLES*DATA_W-1:0] s1_rd_data;

    // Output stage
    logic                         out_valid_q;
    logic [NUM_TABLES*DATA_W-1:0] out_data_q;
    logic [NUM_TABLES*DATA_W-1:0] out_data_d;
    logic [NUM_TABLES-1:0]        out_miss_q;
    logic [NUM_TABLES-1:0]        out_miss_d;

    // Per-table storage: one write port, one synchronous read port.
    // The read register samples the array before the same-edge write lands,
    // which gives read-before-write on a collision.
    for (genvar t = 0; t < NUM_TABLES; t++) begin : g_tbl
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [DATA_W-1:0] rd_q;

        // An out-of-range ld_table matches no table, so the load is dropped.
        assign wr_en[t] = ld_valid && !clear && (ld_index != '0) &&
                          (ld_table == TBL_W'(t));

        // Storage write; entry 0 is never written
        always_ff @(posedge clk) begin
            if (wr_en[t]) begin
                mem_q[ld_index] <= ld_data;
            end
        end

        // Synchronous read for this lane's selector
        always_ff @(posedge clk) begin
            if (lk_valid) begin
                rd_q <= mem_q[lk_sel[t*SEL_BITS +: SEL_BITS]];
            end
        end

        assign s1_rd_data[t*DATA_W +: DATA_W] = rd_q;
    end

    // Next bitmap: clear beats load; bit 0 stays zero. Armed follows the
    // updated bitmap so it moves on the same edge as the completing load/clear.
    always_comb begin
        armed_d = '0;
        for (int t = 0; t < NUM_TABLES; t++) begin
            written_d[t] = written_q[t];
            if (clear) begin
                written_d[t] = '0;
            end else if (wr_en[t]) begin
                written_d[t][ld_index] = 1'b1;
            end
            written_d[t][0] = 1'b0;
            armed_d[t] = &written_d[t][DEPTH-1:1];
        end
    end

    // Bitmap and armed registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TABLES; t++) begin
                written_q[t] <= '0;
            end
            armed_q <= '0;
        end else begin
            for (int t = 0; t < NUM_TABLES; t++) begin
                written_q[t] <= written_d[t];
            end
            armed_q <= armed_d;
        end
    end

    // Hit status from the pre-edge bitmap; selector 0 always hits.
    always_comb begin
        s1_hit_d = '0;
        for (int t = 0; t < NUM_TABLES; t++) begin
            s1_hit_d[t] = written_q[t][lk_sel[t*SEL_BITS +: SEL_BITS]] ||
                          (lk_sel[t*SEL_BITS +: SEL_BITS] == '0);
        end
    end

    // Stage-1 valid; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= lk_valid;
        end
    end

    // Stage-1 selector and hit capture
    always_ff @(posedge clk) begin
        if (lk_valid) begin
            s1_sel_q <= lk_sel;
            s1_hit_q <= s1_hit_d;
        end
    end

    // Output formation; data and miss hold when no result is completing.
    // Selector 0 is masked here since entry 0 of the array is never written.
    always_comb begin
        out_data_d = out_data_q;
        out_miss_d = out_miss_q;
        if (s1_valid_q) begin
            for (int t = 0; t < NUM_TABLES; t++) begin
                if (s1_hit_q[t] && (s1_sel_q[t*SEL_BITS +: SEL_BITS] != '0)) begin
                    out_data_d[t*DATA_W +: DATA_W] = s1_rd_data[t*DATA_W +: DATA_W];
                end else begin
                    out_data_d[t*DATA_W +: DATA_W] = '0;
                end
                out_miss_d[t] = ~s1_hit_q[t];
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_miss_q  <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            out_data_q  <= out_data_d;
            out_miss_q  <= out_miss_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_miss  = out_miss_q;
    assign tbl_armed = armed_q;

endmodule

// File: tb/tb_xpb_lut_ram.sv
// Bench for xpb_lut_ram: directed vectors, a cycle-level behavioural model
// checked every cycle, and literal expectations at key points.
module tb_xpb_lut_ram;

    localparam int SB    = 5;
    localparam int DW    = 64;
    localparam int NT    = 4;
    localparam int TW    = 2;
    localparam int DEPTH = 1 << SB;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              ld_valid;
    logic [TW-1:0]     ld_table;
    logic [SB-1:0]     ld_index;
    logic [DW-1:0]     ld_data;
    logic              lk_valid;
    logic [NT*SB-1:0]  lk_sel;
    logic              out_valid;
    logic [NT*DW-1:0]  out_data;
    logic [NT-1:0]     out_miss;
    logic [NT-1:0]     tbl_armed;

    int n_assert = 0;
    int n_fail   = 0;

    xpb_lut_ram #(.SEL_BITS(SB), .DATA_W(DW), .NUM_TABLES(NT)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .ld_valid(ld_valid), .ld_table(ld_table), .ld_index(ld_index), .ld_data(ld_data),
        .lk_valid(lk_valid), .lk_sel(lk_sel),
        .out_valid(out_valid), .out_data(out_data), .out_miss(out_miss), .tbl_armed(tbl_armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0]    m_mem [NT][DEPTH];
    bit               m_ld  [NT][DEPTH];
    bit               started = 0;
    bit               p1_v;
    logic [NT*DW-1:0] p1_data;
    logic [NT-1:0]    p1_miss;
    logic             exp_valid;
    logic [NT*DW-1:0] exp_data;
    logic [NT-1:0]    exp_miss;
    logic [NT-1:0]    exp_armed;

    always @(posedge clk) begin
        if (!rst_n) begin
            started   = 1;
            p1_v      = 0;
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_miss  = '0;
            exp_armed = '0;
            for (int t = 0; t < NT; t++)
                for (int i = 0; i < DEPTH; i++) m_ld[t][i] = 0;
        end else begin
            // result issued at the previous edge appears now
            exp_valid = p1_v;
            if (p1_v) begin
                exp_data = p1_data;
                exp_miss = p1_miss;
            end
            // result of a lookup issued at this edge, from pre-edge contents
            p1_v = lk_valid;
            if (lk_valid) begin
                for (int t = 0; t < NT; t++) begin
                    int s;
                    s = int'(lk_sel[t*SB +: SB]);
                    if (s == 0) begin
                        p1_data[t*DW +: DW] = '0;
                        p1_miss[t] = 1'b0;
                    end else if (m_ld[t][s]) begin
                        p1_data[t*DW +: DW] = m_mem[t][s];
                        p1_miss[t] = 1'b0;
                    end else begin
                        p1_data[t*DW +: DW] = '0;
                        p1_miss[t] = 1'b1;
                    end
                end
            end
            if (clear) begin
                for (int t = 0; t < NT; t++)
                    for (int i = 0; i < DEPTH; i++) m_ld[t][i] = 0;
            end else if (ld_valid && ld_index != 0 && int'(ld_table) < NT) begin
                m_mem[ld_table][ld_index] = ld_data;
                m_ld[ld_table][ld_index]  = 1;
            end
            for (int t = 0; t < NT; t++) begin
                int cnt;
                cnt = 0;
                for (int i = 1; i < DEPTH; i++) if (m_ld[t][i]) cnt++;
                exp_armed[t] = (cnt == DEPTH - 1);
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            check("tbl_armed", 64'(tbl_armed), 64'(exp_armed));
            check("out_miss", 64'(out_miss), 64'(exp_miss));
            for (int t = 0; t < NT; t++)
                check($sformatf("out_data[%0d]", t), out_data[t*DW +: DW], exp_data[t*DW +: DW]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear    = 1'b0;
        ld_valid = 1'b0;
        lk_valid = 1'b0;
    endtask

    task automatic set_ld(input int t, input int i, input logic [DW-1:0] d);
        ld_valid = 1'b1;
        ld_table = TW'(t);
        ld_index = SB'(i);
        ld_data  = d;
    endtask

    task automatic set_lk(input int s0, input int s1, input int s2, input int s3);
        lk_valid = 1'b1;
        lk_sel   = {SB'(s3), SB'(s2), SB'(s1), SB'(s0)};
    endtask

    function automatic logic [DW-1:0] lane(input int t);
        return out_data[t*DW +: DW];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        ld_table = '0; ld_index = '0; ld_data = '0; lk_sel = '0;
        tick(); tick();
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset armed", 64'(tbl_armed), 64'd0);
        rst_n = 1'b1;
        tick();

        // empty tables: lanes {3,0,31,1}
        set_lk(3, 0, 31, 1);
        tick();
        lk_valid = 1'b0;
        check("t1 not yet valid", 64'(out_valid), 64'd0);
        tick();
        check("t1 valid", 64'(out_valid), 64'd1);
        check("t1 miss", 64'(out_miss), 64'b1101);
        check("t1 data", 64'(out_data == '0), 64'd1);
        check("t1 armed", 64'(tbl_armed), 64'd0);
        tick();

        // two loads, then a lookup
        set_ld(0, 1, 64'h1234); tick();
        set_ld(2, 31, 64'hABCD); tick();
        idle();
        set_lk(1, 0, 31, 0); tick();
        lk_valid = 1'b0;
        check("t2 latency", 64'(out_valid), 64'd0);
        tick();
        check("t2 valid", 64'(out_valid), 64'd1);
        check("t2 lane0", lane(0), 64'h1234);
        check("t2 lane2", lane(2), 64'hABCD);
        check("t2 miss", 64'(out_miss), 64'd0);
        tick();

        // fill table 1 with value = index
        for (int i = 1; i < DEPTH; i++) begin
            set_ld(1, i, DW'(i));
            tick();
            check($sformatf("t3 armed after load %0d", i), 64'(tbl_armed[1]), 64'(i == DEPTH - 1));
        end
        idle();
        for (int i = 1; i < DEPTH; i++) begin
            set_lk(0, i, 0, 0);
            tick();
            if (i >= 2) begin
                check("t3 stream valid", 64'(out_valid), 64'd1);
                check("t3 stream lane1", lane(1), 64'(i - 1));
            end
        end
        lk_valid = 1'b0;
        tick();
        check("t3 last lane1", lane(1), 64'd31);
        tick();
        check("t3 drained", 64'(out_valid), 64'd0);

        // read-before-write collision
        set_ld(0, 5, 64'hAA); tick();
        set_ld(0, 5, 64'hBB); set_lk(5, 0, 0, 0); tick();
        idle(); set_lk(5, 0, 0, 0); tick();
        lk_valid = 1'b0;
        check("t4 old word", lane(0), 64'hAA);
        tick();
        check("t4 new word", lane(0), 64'hBB);
        tick();

        // clear with a competing load and a lookup
        check("t5 armed before", 64'(tbl_armed[1]), 64'd1);
        clear = 1'b1; set_ld(1, 2, 64'hFFFF); set_lk(0, 2, 0, 0); tick();
        idle(); set_lk(0, 2, 0, 0); tick();
        lk_valid = 1'b0;
        check("t5 armed falls", 64'(tbl_armed[1]), 64'd0);
        check("t5 clear-cycle hit data", lane(1), 64'd2);
        check("t5 clear-cycle hit miss", 64'(out_miss[1]), 64'd0);
        tick();
        check("t5 post-clear miss", 64'(out_miss[1]), 64'd1);
        check("t5 post-clear data", lane(1), 64'd0);
        tick();

        // reset while a lookup is in flight
        set_lk(1, 0, 0, 0); tick();
        lk_valid = 1'b0; rst_n = 1'b0; tick();
        check("t6 reset c1", 64'(out_valid), 64'd0);
        rst_n = 1'b1; tick();
        check("t6 reset c2", 64'(out_valid), 64'd0);
        tick();
        check("t6 reset c3", 64'(out_valid), 64'd0);
        check("t6 data cleared", 64'(out_data == '0), 64'd1);

        // index-0 loads do not count toward arming
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_ld(3, i, DW'(64'h300 + i));
            tick();
            check("t7 armed stays low", 64'(tbl_armed[3]), 64'd0);
        end
        idle();
        set_lk(1, 0, 0, 0); tick();
        lk_valid = 1'b0; tick();
        check("t7 sel0 data", lane(3), 64'd0);
        check("t7 miss", 64'(out_miss), 64'b0001);
        set_ld(3, 31, 64'h31F); tick();
        idle();
        check("t7 armed rises", 64'(tbl_armed), 64'b1000);
        set_lk(0, 0, 0, 31); tick();
        lk_valid = 1'b0; tick();
        check("t7 lane3", lane(3), 64'h31F);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
